clock_alarm_core: RTL and testbench

Time-keeping and alarm core of the digital clock. It keeps hours, minutes and seconds in 24-hour format and advances them on a one-second tick. It supports loading the time or an alarm from the keyboard-entry path, and raises an alarm-ring flag and an hourly-chime flag. Its time outputs feed the seven-segment display and the VGA dial renderer; its ring flags gate the audio tone generator and the indicator LEDs.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/ring_timer.sv | 40 ++++
 rtl/clock_alarm_core.sv | 107 ++++++++++
 tb/tb_clock_alarm_core.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time types, limits and the out-of-range clamp used by the
// time and alarm load paths.
package clock_pkg;

  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_HOUR    = 6'd23;
  localparam logic [TIME_W-1:0] MAX_MIN_SEC = 6'd59;

  typedef struct packed {
    logic [TIME_W-1:0] hour;
    logic [TIME_W-1:0] minute;
    logic [TIME_W-1:0] second;
  } hms_t;

  // Each field is clamped on its own; a bad field never disturbs the others.
  function automatic hms_t clamp_hms(input logic [TIME_W-1:0] h,
                                     input logic [TIME_W-1:0] m,
                                     input logic [TIME_W-1:0] s);
    hms_t v;
    v.hour   = (h > MAX_HOUR)    ? '0 : h;
    v.minute = (m > MAX_MIN_SEC) ? '0 : m;
    v.second = (s > MAX_MIN_SEC) ? '0 : s;
    return v;
  endfunction

endpackage

// File: rtl/ring_timer.sv
// Ring flag held for N second ticks after a trigger; stop clears it at once.
// Latency: flag rises the cycle after trigger. Stop has priority over trigger.
module ring_timer #(
  parameter int N = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic stop,
  input  logic tick,
  output logic active
);

  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;

  // The trigger arrives on a tick, so it takes precedence over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (stop) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (trigger) begin
      r_cnt    <= CW'(N);
      r_active <= 1'b1;
    end else if (tick && r_active) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt <= CW'(1)) begin
        r_active <= 1'b0;
      end
    end
  end

  assign active = r_active;

endmodule

// File: rtl/clock_alarm_core.sv
// 24-hour time counter with alarm register, alarm match and hourly chime.
// All outputs registered; ring flags rise together with the matching time.
module clock_alarm_core
  import clock_pkg::*;
#(
  parameter int ALARM_SECS = 30,
  parameter int CHIME_SECS = 5
) (
  input  logic              CLK_50,
  input  logic              reset_en,
  input  logic              sec_tick,
  input  logic              set_time_en,
  input  logic              set_alarm_en,
  input  logic              alarm_stop,
  input  logic [TIME_W-1:0] hour_trans,
  input  logic [TIME_W-1:0] minute_trans,
  input  logic [TIME_W-1:0] second_trans,
  output logic [TIME_W-1:0] clock_hour,
  output logic [TIME_W-1:0] clock_minute,
  output logic [TIME_W-1:0] clock_second,
  output logic [TIME_W-1:0] alarm_hour,
  output logic [TIME_W-1:0] alarm_minute,
  output logic [TIME_W-1:0] alarm_second,
  output logic              alarm_armed,
  output logic              alarm_active,
  output logic              chime_active
);

  hms_t r_time;
  hms_t r_alarm;
  logic r_armed;

  hms_t w_load;
  hms_t w_next;
  logic w_count;
  logic w_alarm_hit;
  logic w_chime_hit;

  assign w_load  = clamp_hms(hour_trans, minute_trans, second_trans);
  assign w_count = sec_tick && !set_time_en;

  always_comb begin
    w_next = r_time;
    if (r_time.second == MAX_MIN_SEC) begin
      w_next.second = '0;
      if (r_time.minute == MAX_MIN_SEC) begin
        w_next.minute = '0;
        w_next.hour   = (r_time.hour == MAX_HOUR) ? '0 : r_time.hour + TIME_W'(1);
      end else begin
        w_next.minute = r_time.minute + TIME_W'(1);
      end
    end else begin
      w_next.second = r_time.second + TIME_W'(1);
    end
  end

  // Match on the incremented value so the flags line up with the new time.
  assign w_alarm_hit = w_count && r_armed && (w_next == r_alarm);
  assign w_chime_hit = w_count && (w_next.minute == '0) && (w_next.second == '0);

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      r_time <= '0;
    end else if (set_time_en) begin
      r_time <= w_load;
    end else if (sec_tick) begin
      r_time <= w_next;
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      r_alarm <= '0;
      r_armed <= 1'b0;
    end else if (set_alarm_en) begin
      r_alarm <= w_load;
      r_armed <= 1'b1;
    end
  end

  ring_timer #(.N(ALARM_SECS)) u_alarm_ring (
    .clk     (CLK_50),
    .rst_n   (reset_en),
    .trigger (w_alarm_hit),
    .stop    (alarm_stop),
    .tick    (sec_tick),
    .active  (alarm_active)
  );

  ring_timer #(.N(CHIME_SECS)) u_chime_ring (
    .clk     (CLK_50),
    .rst_n   (reset_en),
    .trigger (w_chime_hit),
    .stop    (1'b0),
    .tick    (sec_tick),
    .active  (chime_active)
  );

  assign clock_hour   = r_time.hour;
  assign clock_minute = r_time.minute;
  assign clock_second = r_time.second;
  assign alarm_hour   = r_alarm.hour;
  assign alarm_minute = r_alarm.minute;
  assign alarm_second = r_alarm.second;
  assign alarm_armed  = r_armed;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Bench for clock_alarm_core: directed scenarios plus random traffic, checked
// against a seconds-of-day reference model.
module tb_clock_alarm_core;

  localparam int AS  = 30;
  localparam int CS  = 5;
  localparam int DAY = 86400;

  logic       CLK_50 = 1'b0;
  logic       reset_en = 1'b0;
  logic       sec_tick = 1'b0;
  logic       set_time_en = 1'b0;
  logic       set_alarm_en = 1'b0;
  logic       alarm_stop = 1'b0;
  logic [5:0] hour_trans = '0;
  logic [5:0] minute_trans = '0;
  logic [5:0] second_trans = '0;
  logic [5:0] clock_hour, clock_minute, clock_second;
  logic [5:0] alarm_hour, alarm_minute, alarm_second;
  logic       alarm_armed, alarm_active, chime_active;

  int checks = 0;
  int errors = 0;

  // Reference state: times as seconds of day, ring lengths as seconds left.
  int m_t, m_a, m_a_rem, m_c_rem;
  bit m_armed, m_aa, m_ca;

  clock_alarm_core #(.ALARM_SECS(AS), .CHIME_SECS(CS)) dut (
    .CLK_50       (CLK_50),
    .reset_en     (reset_en),
    .sec_tick     (sec_tick),
    .set_time_en  (set_time_en),
    .set_alarm_en (set_alarm_en),
    .alarm_stop   (alarm_stop),
    .hour_trans   (hour_trans),
    .minute_trans (minute_trans),
    .second_trans (second_trans),
    .clock_hour   (clock_hour),
    .clock_minute (clock_minute),
    .clock_second (clock_second),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .alarm_second (alarm_second),
    .alarm_armed  (alarm_armed),
    .alarm_active (alarm_active),
    .chime_active (chime_active)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pk(input int t);
    return {6'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic int clampf(input int h, input int m, input int s);
    return ((h > 23) ? 0 : h) * 3600 + ((m > 59) ? 0 : m) * 60 + ((s > 59) ? 0 : s);
  endfunction

  task automatic model_reset();
    m_t = 0; m_a = 0; m_a_rem = 0; m_c_rem = 0;
    m_armed = 0; m_aa = 0; m_ca = 0;
  endtask

  task automatic model_step();
    int  old_a;
    bit  old_armed, trig_a, trig_c;
    int  ld;
    old_a = m_a; old_armed = m_armed; trig_a = 0; trig_c = 0;
    ld = clampf(hour_trans, minute_trans, second_trans);
    if (set_time_en) m_t = ld;
    else if (sec_tick) begin
      m_t = (m_t + 1) % DAY;
      trig_a = old_armed && (m_t == old_a);
      trig_c = (m_t % 3600) == 0;
    end
    if (set_alarm_en) begin m_a = ld; m_armed = 1; end
    if (alarm_stop) begin m_aa = 0; m_a_rem = 0; end
    else if (trig_a) begin m_aa = 1; m_a_rem = AS; end
    else if (sec_tick && m_aa) begin m_a_rem--; if (m_a_rem == 0) m_aa = 0; end
    if (trig_c) begin m_ca = 1; m_c_rem = CS; end
    else if (sec_tick && m_ca) begin m_c_rem--; if (m_c_rem == 0) m_ca = 0; end
  endtask

  task automatic check_all();
    check("time",   {14'd0, clock_hour, clock_minute, clock_second}, {14'd0, pk(m_t)});
    check("alarm",  {14'd0, alarm_hour, alarm_minute, alarm_second}, {14'd0, pk(m_a)});
    check("armed",  32'(alarm_armed),  32'(m_armed));
    check("a_ring", 32'(alarm_active), 32'(m_aa));
    check("c_ring", 32'(chime_active), 32'(m_ca));
  endtask

  // One clock with the given inputs; called and returning at a falling edge.
  task automatic cyc(input bit tk, input bit st, input bit sa, input bit sp,
                     input int h, input int m, input int s);
    sec_tick = tk; set_time_en = st; set_alarm_en = sa; alarm_stop = sp;
    hour_trans = 6'(h); minute_trans = 6'(m); second_trans = 6'(s);
    @(posedge CLK_50);
    model_step();
    @(negedge CLK_50);
    check_all();
    sec_tick = 0; set_time_en = 0; set_alarm_en = 0; alarm_stop = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_50);
    reset_en = 0;
    model_reset();
    @(negedge CLK_50);
    check_all();
    reset_en = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Free-running count from reset, then the midnight roll with chime.
    ticks(61);
    check("t61", {14'd0, clock_hour, clock_minute, clock_second}, {14'd0, pk(61)});
    cyc(0, 1, 0, 0, 23, 59, 58);
    ticks(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("midnight", {14'd0, clock_hour, clock_minute, clock_second}, 32'd0);
    check("chime_rise", 32'(chime_active), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Alarm rings for exactly AS seconds.
    cyc(0, 0, 1, 0, 7, 30, 0);
    cyc(0, 1, 0, 0, 7, 29, 59);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("alarm_rise", 32'(alarm_active), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    ticks(AS - 1);
    check("alarm_hold", 32'(alarm_active), 32'd1);
    ticks(1);
    check("alarm_end", 32'(alarm_active), 32'd0);

    // Stop after three ticks of ringing.
    cyc(0, 1, 0, 0, 7, 29, 59);
    ticks(4);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("alarm_stop", 32'(alarm_active), 32'd0);

    // No armed alarm: midnight chimes only; loading a matching time never rings.
    do_reset();
    cyc(0, 1, 0, 0, 23, 59, 50);
    ticks(10);
    check("noarm_alarm", 32'(alarm_active), 32'd0);
    check("noarm_chime", 32'(chime_active), 32'd1);
    cyc(0, 1, 1, 0, 7, 30, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("load_no_trig", 32'(alarm_active), 32'd0);

    // Out-of-range fields clamp; ticks during setting are ignored.
    for (int i = 0; i < 4; i++) cyc(i[0], 1, 0, 0, 25, 61, 30);
    check("clamp", {14'd0, clock_hour, clock_minute, clock_second}, {14'd0, pk(30)});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int mode, t;
      bit st, sa;
      st = ($urandom_range(0, 39) == 0);
      sa = ($urandom_range(0, 79) == 0);
      mode = $urandom_range(0, 3);
      case (mode)
        0: t = -1;
        1: t = (m_a + DAY - $urandom_range(0, 4)) % DAY;
        2: t = $urandom_range(0, 23) * 3600 + 3595 + $urandom_range(0, 4);
        default: t = $urandom_range(0, DAY - 1);
      endcase
      if (t < 0)
        cyc($urandom_range(0, 1), st, sa, $urandom_range(0, 59) == 0,
            $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      else
        cyc($urandom_range(0, 1), st, sa, $urandom_range(0, 59) == 0,
            (t / 3600) % 24, (t / 60) % 60, t % 60);
    end

    // Asynchronous reset in the middle of both rings.
    cyc(0, 1, 1, 0, 11, 59, 59);
    cyc(0, 0, 1, 0, 12, 0, 0);
    ticks(3);
    check("pre_rst_a", 32'(alarm_active), 32'd1);
    check("pre_rst_c", 32'(chime_active), 32'd1);
    #3 reset_en = 0;
    #2;
    model_reset();
    check("arst_time", {14'd0, clock_hour, clock_minute, clock_second}, 32'd0);
    check("arst_alarm", {14'd0, alarm_hour, alarm_minute, alarm_second}, 32'd0);
    check("arst_flags", {29'd0, alarm_armed, alarm_active, chime_active}, 32'd0);
    @(negedge CLK_50);
    reset_en = 1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
